// File: rtl/multicycle_alu_if.sv
// Request/response bundle for the multi-cycle ALU: operands in, results and
// completion status out.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic                    in_valid;
  logic                    in_ready;
  logic [3:0]              op;
  logic signed [WIDTH-1:0] in1;
  logic signed [WIDTH-1:0] in2;
  logic [SHW-1:0]          shamt;
  logic                    out_valid;
  logic [WIDTH-1:0]        result;
  logic [WIDTH-1:0]        hi;
  logic                    zero;
  logic                    div_by_zero;

  modport master (
    output in_valid, op, in1, in2, shamt,
    input  in_ready, out_valid, result, hi, zero, div_by_zero
  );

  modport slave (
    input  in_valid, op, in1, in2, shamt,
    output in_ready, out_valid, result, hi, zero, div_by_zero
  );
endinterface

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative signed multiply
// (shift-add) and divide (restoring), one bit per cycle on magnitudes.
//
// state | meaning
// IDLE  | ready for a request; single-cycle ops complete from here
// MUL   | shift-add iteration, one multiplier bit per cycle
// DIV   | restoring division, one quotient bit per cycle
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  multicycle_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam logic [3:0] OP_DIV = 4'b1010;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t               state, state_nxt;
  logic [SHW:0]         cnt, cnt_nxt;
  logic [2*WIDTH-1:0]   acc, acc_step, prod;
  logic [WIDTH-1:0]     opb, mag1, mag2, a_save;
  logic                 neg_q, neg_r, dz_op;
  logic                 accept, done;
  logic [WIDTH-1:0]     alu_res, quot, rem, fin_lo, fin_hi;
  logic [WIDTH:0]       mul_sum, rem_sh, rem_diff;

  logic                 ovalid_q, zero_q, dz_q;
  logic [WIDTH-1:0]     result_q, hi_q;

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = ovalid_q;
  assign bus.result      = result_q;
  assign bus.hi          = hi_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dz_q;

  assign accept  = bus.in_valid && (state == IDLE);
  assign cnt_nxt = cnt - 1'b1;
  assign mag1    = bus.in1[WIDTH-1] ? WIDTH'(-bus.in1) : bus.in1;
  assign mag2    = bus.in2[WIDTH-1] ? WIDTH'(-bus.in2) : bus.in2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.op == OP_MUL)      state_nxt = MUL;
          else if (bus.op == OP_DIV) state_nxt = DIV;
        end
      end
      MUL, DIV: begin
        if (cnt_nxt == '0) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (bus.op)
      OP_ADD:  alu_res = bus.in1 + bus.in2;
      OP_SUB:  alu_res = bus.in1 - bus.in2;
      OP_AND:  alu_res = bus.in1 & bus.in2;
      OP_OR:   alu_res = bus.in1 | bus.in2;
      OP_SLL:  alu_res = bus.in1 << bus.shamt;
      OP_SRL:  alu_res = bus.in1 >> bus.shamt;
      OP_SRA:  alu_res = bus.in1 >>> bus.shamt;
      OP_NOR:  alu_res = ~(bus.in1 | bus.in2);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (bus.in1 < bus.in2)};
      default: alu_res = '0;
    endcase
  end

  // acc holds {partial product} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    rem_diff = rem_sh - {1'b0, opb};
    if (state == MUL)      acc_step = {mul_sum, acc[WIDTH-1:1]};
    else if (rem_diff[WIDTH]) acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else                   acc_step = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    prod = neg_q ? -acc_step : acc_step;
    quot = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem  = neg_r ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];

    if (state == MUL) begin
      fin_lo = prod[WIDTH-1:0];
      fin_hi = prod[2*WIDTH-1:WIDTH];
    end else if (dz_op) begin
      fin_lo = '1;
      fin_hi = a_save;
    end else begin
      fin_lo = quot;
      fin_hi = rem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz_op    <= 1'b0;
      a_save   <= '0;
      ovalid_q <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      ovalid_q <= 1'b0;
      if (accept) begin
        cnt    <= (SHW+1)'(WIDTH);
        neg_q  <= bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1];
        neg_r  <= bus.in1[WIDTH-1];
        dz_op  <= (bus.in2 == '0);
        a_save <= bus.in1;
        if (bus.op == OP_MUL) begin
          acc <= {{WIDTH{1'b0}}, mag2};
          opb <= mag1;
        end else begin
          acc <= {{WIDTH{1'b0}}, mag1};
          opb <= mag2;
        end
        if (bus.op != OP_MUL && bus.op != OP_DIV) begin
          ovalid_q <= 1'b1;
          result_q <= alu_res;
          hi_q     <= '0;
          zero_q   <= (alu_res == '0);
          dz_q     <= 1'b0;
        end
      end else if (state != IDLE) begin
        cnt <= cnt_nxt;
        acc <= acc_step;
        if (done) begin
          ovalid_q <= 1'b1;
          result_q <= fin_lo;
          hi_q     <= fin_hi;
          zero_q   <= (fin_lo == '0);
          dz_q     <= (state == DIV) && dz_op;
        end
      end
    end
  end
endmodule
